// File: rtl/hd_beat_gen.sv
// Beat/phase timing generator for the hardwired controller.
// Produces one-hot beats W[3:1] and phases T1..T3, owns run/halt state and
// counts completed instruction cycles. All outputs come straight from flops.
module hd_beat_gen #(
  parameter int unsigned PH_LEN = 1,  // clocks per phase, 1..15
  parameter int unsigned CNT_W  = 16  // completed-cycle counter width
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic             DP,
  input  logic             SHORT,
  input  logic             LONG,
  input  logic             STOP,
  output logic [2:0]       W,
  output logic [2:0]       T,
  output logic             RUN,
  output logic             BEAT_END,
  output logic [CNT_W-1:0] CYC_CNT
);

  localparam logic [3:0] PhLast = 4'(PH_LEN - 1);

  typedef enum logic {StHalt, StRun} state_e;

  state_e           state_q, state_d;
  logic [2:0]       w_q, w_d;
  logic [2:0]       t_q, t_d;
  logic [3:0]       ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             be_q, be_d;

  // Synchroniser stages; third stage holds the previous value for edge detect.
  logic sync1_q, sync2_q, sync3_q;
  logic start_pulse;

  // START synchroniser and edge history; resets high so a held START never fires.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= START;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign start_pulse = sync2_q & ~sync3_q;

  // State register and registered datapath.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= StHalt;
      w_q     <= 3'b001;
      t_q     <= 3'b000;
      ph_q    <= 4'd0;
      cnt_q   <= '0;
      be_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      t_q     <= t_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      be_q    <= be_d;
    end
  end

  // Next-state: phase sequencing, beat selection at beat end, halt handling.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    t_d     = t_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StHalt: begin
        if (start_pulse) begin
          // Resume at T1 of whatever beat was already selected.
          state_d = StRun;
          t_d     = 3'b001;
          ph_d    = 4'd0;
        end
      end
      StRun: begin
        if (ph_q != PhLast) begin
          ph_d = ph_q + 4'd1;
        end else begin
          ph_d = 4'd0;
          if (t_q == 3'b100) begin
            // Beat end: requests are only looked at on this edge.
            case (w_q)
              3'b001:  w_d = SHORT ? 3'b001 : 3'b010;
              3'b010:  w_d = LONG ? 3'b100 : 3'b001;
              default: w_d = 3'b001;
            endcase
            if (w_d == 3'b001) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (STOP || DP) begin
              state_d = StHalt;
              t_d     = 3'b000;
            end else begin
              t_d = 3'b001;
            end
          end else begin
            t_d = {t_q[1:0], 1'b0};
          end
        end
      end
      default: begin
        state_d = StHalt;
      end
    endcase
    // Registered pulse lands on the last clock of T3.
    be_d = (state_d == StRun) && (t_d == 3'b100) && (ph_d == PhLast);
  end

  // Outputs are pure register taps.
  always_comb begin
    W        = w_q;
    T        = t_q;
    RUN      = (state_q == StRun);
    BEAT_END = be_q;
    CYC_CNT  = cnt_q;
  end

endmodule

// File: tb/tb_hd_beat_gen.sv
// Directed self-checking bench for hd_beat_gen. Instance a uses PH_LEN=1,
// instance b uses PH_LEN=3 with a narrow counter to reach the wrap point.
module tb_hd_beat_gen;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic start = 1'b0;
  logic dp = 1'b0;
  logic short_r = 1'b0;
  logic long_r = 1'b0;
  logic stop = 1'b0;

  logic [2:0]  w_a, t_a, w_b, t_b;
  logic        run_a, be_a, run_b, be_b;
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;

  int n_assert = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  hd_beat_gen #(.PH_LEN(1), .CNT_W(16)) u_a (
    .CLK(clk), .CLR(clr), .START(start), .DP(dp), .SHORT(short_r), .LONG(long_r),
    .STOP(stop), .W(w_a), .T(t_a), .RUN(run_a), .BEAT_END(be_a), .CYC_CNT(cnt_a)
  );

  hd_beat_gen #(.PH_LEN(3), .CNT_W(3)) u_b (
    .CLK(clk), .CLR(clr), .START(start), .DP(dp), .SHORT(short_r), .LONG(long_r),
    .STOP(stop), .W(w_b), .T(t_b), .RUN(run_b), .BEAT_END(be_b), .CYC_CNT(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset state
    #2 clr = 1'b1;
    #1;
    chk("rst_w", w_a, 3'b001);
    chk("rst_t", t_a, 3'b000);
    chk("rst_run", run_a, 0);
    chk("rst_be", be_a, 0);
    chk("rst_cnt", cnt_a, 0);
    tick(2);
    clr = 1'b0;
    tick(4);
    chk("idle_run", run_a, 0);

    // Start, free-running W1,W2,W1 with PH_LEN=1
    start = 1'b1;
    tick(3);
    chk("start_run", run_a, 1);
    chk("start_t", t_a, 3'b001);
    chk("start_w", w_a, 3'b001);
    tick(1);
    chk("t2", t_a, 3'b010);
    tick(1);
    chk("t3", t_a, 3'b100);
    chk("be_on", be_a, 1);
    tick(1);
    chk("w1_to_w2", w_a, 3'b010);
    chk("be_off", be_a, 0);
    chk("cnt_w2", cnt_a, 0);
    chk("t1_again", t_a, 3'b001);
    tick(3);
    chk("w2_to_w1", w_a, 3'b001);
    chk("cnt_1", cnt_a, 1);
    exp_cnt = 1;

    // SHORT: W1 repeats, counter bumps every beat
    short_r = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(2);
      chk("short_be", be_a, 1);
      tick(1);
      exp_cnt++;
      chk("short_w", w_a, 3'b001);
      chk("short_cnt", cnt_a, exp_cnt);
      chk("short_be_off", be_a, 0);
    end

    // SHORT wins over LONG in W1
    long_r = 1'b1;
    tick(3);
    exp_cnt++;
    chk("sl_w", w_a, 3'b001);
    chk("sl_cnt", cnt_a, exp_cnt);
    // LONG alone: W1 -> W2 -> W3 -> W1
    short_r = 1'b0;
    tick(3);
    chk("long_w2", w_a, 3'b010);
    chk("long_cnt_w2", cnt_a, exp_cnt);
    tick(3);
    chk("long_w3", w_a, 3'b100);
    chk("long_cnt_w3", cnt_a, exp_cnt);
    tick(3);
    exp_cnt++;
    chk("long_w1", w_a, 3'b001);
    chk("long_cnt_w1", cnt_a, exp_cnt);
    long_r = 1'b0;

    // STOP at end of W1 beat: halt with W2 selected
    stop = 1'b1;
    tick(3);
    chk("stop_run", run_a, 0);
    chk("stop_t", t_a, 3'b000);
    chk("stop_w", w_a, 3'b010);
    chk("stop_cnt", cnt_a, exp_cnt);
    stop = 1'b0;
    tick(5);
    chk("held_start_run", run_a, 0);
    chk("held_w", w_a, 3'b010);
    start = 1'b0;
    tick(3);
    start = 1'b1;
    tick(3);
    chk("resume_run", run_a, 1);
    chk("resume_t", t_a, 3'b001);
    chk("resume_w", w_a, 3'b010);
    tick(3);
    exp_cnt++;
    chk("resume_next_w", w_a, 3'b001);
    chk("resume_cnt", cnt_a, exp_cnt);

    // CLR mid-T2 of W2 with START high
    tick(3);
    chk("pre_clr_w", w_a, 3'b010);
    tick(1);
    chk("pre_clr_t", t_a, 3'b010);
    #2 clr = 1'b1;
    #1;
    chk("clr_w", w_a, 3'b001);
    chk("clr_t", t_a, 3'b000);
    chk("clr_cnt", cnt_a, 0);
    chk("clr_run", run_a, 0);
    tick(2);
    clr = 1'b0;
    tick(6);
    chk("post_clr_run", run_a, 0);
    chk("post_clr_run_b", run_b, 0);

    // DP with PH_LEN=3 on instance b: one 9-clock beat per START edge
    dp = 1'b1;
    start = 1'b0;
    tick(3);
    start = 1'b1;
    tick(3);
    chk("dp_run", run_b, 1);
    chk("dp_t1", t_b, 3'b001);
    tick(3);
    chk("dp_t2", t_b, 3'b010);
    tick(4);
    chk("dp_t3", t_b, 3'b100);
    chk("dp_be_early", be_b, 0);
    tick(1);
    chk("dp_be_9th", be_b, 1);
    tick(1);
    chk("dp_halt_run", run_b, 0);
    chk("dp_halt_t", t_b, 3'b000);
    chk("dp_halt_w", w_b, 3'b010);
    chk("dp_halt_be", be_b, 0);
    start = 1'b0;
    tick(3);
    start = 1'b1;
    tick(3);
    chk("dp2_run", run_b, 1);
    chk("dp2_w", w_b, 3'b010);
    tick(9);
    chk("dp2_halt_run", run_b, 0);
    chk("dp2_w1", w_b, 3'b001);
    chk("dp2_cnt", cnt_b, 1);

    // Counter wrap on the 3-bit counter of instance b
    dp = 1'b0;
    short_r = 1'b1;
    start = 1'b0;
    tick(3);
    start = 1'b1;
    tick(3);
    for (int k = 1; k <= 7; k++) begin
      tick(9);
      chk("wrap_cnt", cnt_b, (1 + k) % 8);
    end
    short_r = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hd_beat_gen.md
Name: hd_beat_gen

Overview:
- Timing generator for the hardwired controller. Produces the beat signals W[3:1] and phase signals T1..T3 that the controller decodes.
- Consumes the controller's SHORT, LONG and STOP requests, which select the next beat or halt the machine.
- Sits between the front-panel START/DP inputs and the controller. It owns run/halt state and an instruction-cycle counter.

Parameters:
- PH_LEN, 1: clock cycles per phase (T1, T2, T3 each last PH_LEN clocks); legal range 1..15.
- CNT_W, 16: width of the completed-cycle counter.

Ports:
- CLK  in  1  master clock; all state updates on rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- START  in  1  front-panel start; asynchronous level input.
- DP  in  1  single-beat mode; when 1, halt after every beat.
- SHORT  in  1  from controller; end instruction after W1.
- LONG  in  1  from controller; extend instruction to W3.
- STOP  in  1  from controller; halt at end of current beat.
- W  out  3  beat one-hot; bit0=W1, bit1=W2, bit2=W3.
- T  out  3  phase one-hot; bit0=T1, bit1=T2, bit2=T3; 000 when halted.
- RUN  out  1  1 while beats are being generated.
- BEAT_END  out  1  single-cycle pulse on the last clock of T3.
- CYC_CNT  out  CNT_W  count of completed instruction cycles.

Behaviour:
- One clock; reset is asynchronous and active-high: CLK, CLR.
- Reset (CLR=1, asynchronous, any time including mid-beat) forces: W=001, T=000, RUN=0, BEAT_END=0, CYC_CNT=0, phase counter=0, state HALT. All START synchroniser flops reset to 1.
- START path: 2-flop synchroniser, then rising-edge detect giving a 1-cycle pulse. START held high across reset release produces no start; a fresh low-to-high transition is required.
- State machine HALT/RUN:
  - HALT plus start pulse: enter RUN next edge, T=001, phase counter=0. W is unchanged (beat resumes where it stopped).
  - RUN, START pulses are ignored.
- RUN phase sequencing:
  - Phase counter counts 0..PH_LEN-1 within each phase.
  - At the count of PH_LEN-1, T advances 001->010->100.
  - Each beat lasts exactly 3*PH_LEN clocks.
- Beat end is the last clock of T3:
  - BEAT_END=1 on that clock only.
  - SHORT, LONG, STOP and DP are sampled on the edge that ends the beat.
  - Values at any other time are ignored.
- Next-beat rule, applied at beat end:
  - W1: SHORT=1 -> W1; else -> W2. SHORT wins over LONG; LONG is ignored in W1.
  - W2: LONG=1 -> W3; else -> W1.
  - W3: -> W1 unconditionally; SHORT and LONG are ignored.
- CYC_CNT increments by 1 on every beat end whose next beat is W1. It wraps from 2^CNT_W-1 to 0.
- Halt at beat end: if STOP=1 or DP=1, W still advances per the next-beat rule and CYC_CNT still updates, then RUN=0, T=000, state HALT.
- Restart after halt resumes at T1 of the already-selected W.
- No output is combinationally dependent on inputs; all outputs are registered. Latency:
  - start pulse to T=001 is 1 clock.
  - synchroniser plus edge-detect adds 2-3 clocks from the START pin.

Test Plan:
- Reset then START 0->1, no requests, PH_LEN=1 -> RUN=1 about 3 clocks later; T cycles 001,010,100. W sequence is W1,W2,W1,W2...; CYC_CNT=1 after the second beat end.
- SHORT=1 at each W1 beat end -> W stays 001 continuously; CYC_CNT increments every 3 clocks; BEAT_END pulses every 3 clocks.
- LONG=1 at W2 beat end, SHORT=1 and LONG=1 at W1 -> W1 repeats (SHORT wins). Then SHORT=0, LONG=1 -> W1,W2,W3,W1, with CYC_CNT +1 only on W3->W1.
- STOP=1 at end of a W1 beat with SHORT=0 -> RUN=0, T=000, W=010 held. START held high changes nothing; a new START edge resumes at T1 of W2.
- DP=1, PH_LEN=3 -> each START edge yields exactly one 9-clock beat, then halt. BEAT_END pulses once per beat, on the 9th clock.
- CLR asserted mid-T2 of W2 with START high -> outputs reset immediately (W=001, T=000, CYC_CNT=0). After CLR release with START still high there is no run until START goes low then high.
